// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline-stage hazard inputs and per-register hold/bubble controls.
// The master side is the pipeline (or a bench); the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 32
);

   logic [4:0]       IDRs1;
   logic [4:0]       IDRs2;
   logic             IDRs1Used;
   logic             IDRs2Used;
   logic [4:0]       EXRd;
   logic             EXMemRead;
   logic             EXBranchTaken;
   logic             MulDivStart;
   logic             MulDivDone;
   logic             DMemReq;
   logic             DMemReady;

   logic             PcStall;
   logic             IFIDStall;
   logic             IFIDFlush;
   logic             IDEXStall;
   logic             IDEXFlush;
   logic             EXMEMStall;
   logic             EXMEMFlush;
   logic             MEMWBStall;
   logic             MEMWBFlush;
   logic             MulDivError;
   logic [CNT_W-1:0] StallCount;
   logic [CNT_W-1:0] FlushCount;

   modport master (
      output IDRs1, IDRs2, IDRs1Used, IDRs2Used, EXRd, EXMemRead, EXBranchTaken,
             MulDivStart, MulDivDone, DMemReq, DMemReady,
      input  PcStall, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush, EXMEMStall,
             EXMEMFlush, MEMWBStall, MEMWBFlush, MulDivError, StallCount, FlushCount
   );

   modport slave (
      input  IDRs1, IDRs2, IDRs1Used, IDRs2Used, EXRd, EXMemRead, EXBranchTaken,
             MulDivStart, MulDivDone, DMemReq, DMemReady,
      output PcStall, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush, EXMEMStall,
             EXMEMFlush, MEMWBStall, MEMWBFlush, MulDivError, StallCount, FlushCount
   );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves data-memory wait, mul/div occupancy, EX redirects and load-use hazards in
// that priority order, drives hold/bubble controls for every pipeline register, and
// keeps wrapping performance counters of stalled cycles and accepted redirects.
module pipeline_hazard_ctrl #(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz
);

   localparam int BUSY_W = $clog2(MD_TIMEOUT + 1);
   localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(MD_TIMEOUT);
   localparam logic [BUSY_W-1:0] BUSY_ONE   = BUSY_W'(1);

   typedef enum logic {
      RUN,
      MD_BUSY
   } state_e;

   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_DMEM,
      CAUSE_MULDIV,
      CAUSE_REDIRECT,
      CAUSE_LOADUSE
   } cause_e;

   state_e            state_q, state_d;
   logic [BUSY_W-1:0] busyCnt_q, busyCnt_d;
   logic              mdErr_q, mdErr_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;

   logic   dmemWait;
   logic   mdBusy;
   logic   rs1Hit;
   logic   rs2Hit;
   logic   loadUse;
   cause_e cause;

   logic pcStallRaw, ifidStallRaw, idexStallRaw, exmemStallRaw, memwbStallRaw;
   logic ifidFlushRaw, idexFlushRaw, exmemFlushRaw, memwbFlushRaw;
   logic pcStall;

   // A MEM access that is requested but not yet acknowledged holds the whole pipe.
   assign dmemWait = hz.DMemReq & ~hz.DMemReady;

   // The mul/div unit occupies EX from its start cycle until the cycle its result is valid;
   // in the completion cycle the result is allowed to advance, so no stall is raised.
   assign mdBusy = ((state_q == RUN)     &  hz.MulDivStart) |
                   ((state_q == MD_BUSY) & ~hz.MulDivDone);

   // A load in EX feeding an operand read in ID; x0 is hard-wired and never a producer.
   assign rs1Hit  = hz.IDRs1Used & (hz.IDRs1 == hz.EXRd);
   assign rs2Hit  = hz.IDRs2Used & (hz.IDRs2 == hz.EXRd);
   assign loadUse = hz.EXMemRead & (hz.EXRd != 5'd0) & (rs1Hit | rs2Hit);

   // Pick the single winning hazard; a redirect masks a same-cycle load-use because the
   // instruction in ID is on the wrong path and is about to be squashed anyway.
   always_comb begin
      cause = CAUSE_NONE;
      if (dmemWait) begin
         cause = CAUSE_DMEM;
      end else if (mdBusy) begin
         cause = CAUSE_MULDIV;
      end else if (hz.EXBranchTaken) begin
         cause = CAUSE_REDIRECT;
      end else if (loadUse) begin
         cause = CAUSE_LOADUSE;
      end
   end

   // FSM state register plus the busy-cycle counter and the one-cycle timeout pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         busyCnt_q <= '0;
         mdErr_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         busyCnt_q <= busyCnt_d;
         mdErr_q   <= mdErr_d;
      end
   end

   // FSM next state: a memory wait freezes both state and busy counter; a mul/div that
   // never reports done is released after MD_TIMEOUT busy cycles with an error pulse.
   always_comb begin
      state_d   = state_q;
      busyCnt_d = busyCnt_q;
      mdErr_d   = 1'b0;
      if (!dmemWait) begin
         case (state_q)
            RUN: begin
               if (hz.MulDivStart) begin
                  state_d   = MD_BUSY;
                  busyCnt_d = BUSY_ONE;
               end
            end
            MD_BUSY: begin
               if (hz.MulDivDone) begin
                  state_d = RUN;
               end else if (busyCnt_q >= BUSY_LIMIT) begin
                  state_d = RUN;
                  mdErr_d = 1'b1;
               end else begin
                  busyCnt_d = busyCnt_q + BUSY_ONE;
               end
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   // FSM outputs: decode the winning hazard into raw hold/bubble requests; everything is
   // held at zero while reset is asserted so the pipeline sees a clean start.
   always_comb begin
      pcStallRaw    = 1'b0;
      ifidStallRaw  = 1'b0;
      idexStallRaw  = 1'b0;
      exmemStallRaw = 1'b0;
      memwbStallRaw = 1'b0;
      ifidFlushRaw  = 1'b0;
      idexFlushRaw  = 1'b0;
      exmemFlushRaw = 1'b0;
      memwbFlushRaw = 1'b0;
      if (rst) begin
         case (cause)
            CAUSE_DMEM: begin
               pcStallRaw    = 1'b1;
               ifidStallRaw  = 1'b1;
               idexStallRaw  = 1'b1;
               exmemStallRaw = 1'b1;
               memwbStallRaw = 1'b1;
               memwbFlushRaw = 1'b1;
            end
            CAUSE_MULDIV: begin
               pcStallRaw    = 1'b1;
               ifidStallRaw  = 1'b1;
               idexStallRaw  = 1'b1;
               exmemFlushRaw = 1'b1;
            end
            CAUSE_REDIRECT: begin
               ifidFlushRaw = 1'b1;
               idexFlushRaw = 1'b1;
            end
            CAUSE_LOADUSE: begin
               pcStallRaw   = 1'b1;
               ifidStallRaw = 1'b1;
               idexFlushRaw = 1'b1;
            end
            default: begin
               pcStallRaw = 1'b0;
            end
         endcase
      end
   end

   // A register asked both to hold and to clear is cleared: the bubble takes precedence.
   assign pcStall       = pcStallRaw;
   assign hz.PcStall    = pcStall;
   assign hz.IFIDStall  = ifidStallRaw  & ~ifidFlushRaw;
   assign hz.IDEXStall  = idexStallRaw  & ~idexFlushRaw;
   assign hz.EXMEMStall = exmemStallRaw & ~exmemFlushRaw;
   assign hz.MEMWBStall = memwbStallRaw & ~memwbFlushRaw;
   assign hz.IFIDFlush  = ifidFlushRaw;
   assign hz.IDEXFlush  = idexFlushRaw;
   assign hz.EXMEMFlush = exmemFlushRaw;
   assign hz.MEMWBFlush = memwbFlushRaw;
   assign hz.MulDivError = mdErr_q;

   // Performance counters: one count per PC-held cycle and per accepted redirect, wrapping.
   always_comb begin
      stallCnt_d = stallCnt_q + CNT_W'(pcStall);
      flushCnt_d = flushCnt_q + CNT_W'(cause == CAUSE_REDIRECT);
   end

   // Performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stallCnt_q <= '0;
         flushCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
         flushCnt_q <= flushCnt_d;
      end
   end

   assign hz.StallCount = stallCnt_q;
   assign hz.FlushCount = flushCnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed hazard scenarios followed by
// random traffic, scored against a cycle-level behavioural model via an expectation queue.
module tb_pipeline_hazard_ctrl;

   localparam int MD_TIMEOUT = 8;
   localparam int CNT_W      = 32;

   logic clk = 1'b0;
   logic rst;

   // Free-running 10-time-unit clock.
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

   pipeline_hazard_ctrl #(
      .MD_TIMEOUT(MD_TIMEOUT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (hif)
   );

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1Used;
      logic       rs2Used;
      logic [4:0] rd;
      logic       memRead;
      logic       branch;
      logic       mdStart;
      logic       mdDone;
      logic       dReq;
      logic       dReady;
   } stim_t;

   // ctrl bit order: Pc, IFIDStall, IFIDFlush, IDEXStall, IDEXFlush, EXMEMStall, EXMEMFlush, MEMWBStall, MEMWBFlush
   typedef struct {
      logic [8:0]       ctrl;
      logic             err;
      logic [CNT_W-1:0] stallCnt;
      logic [CNT_W-1:0] flushCnt;
   } expect_t;

   expect_t expQ[$];
   int testsRun    = 0;
   int testsFailed = 0;

   // Reference model state: whether a mul/div is occupying EX and for how many cycles.
   bit               mdInFlight;
   int               mdAge;
   bit               modelErr;
   logic [CNT_W-1:0] modelStalls;
   logic [CNT_W-1:0] modelFlushes;

   function automatic stim_t idleStim();
      stim_t s;
      s = '0;
      s.dReady = 1'b1;
      return s;
   endfunction

   task automatic modelReset();
      mdInFlight   = 1'b0;
      mdAge        = 0;
      modelErr     = 1'b0;
      modelStalls  = '0;
      modelFlushes = '0;
   endtask

   // One pipeline cycle of the hazard rules: produce this cycle's expected outputs, then
   // advance the model across the coming clock edge.
   task automatic modelStep(input stim_t s, output expect_t e);
      bit waitMem, busy, hazard;
      bit pc, ifS, ifF, idS, idF, exS, exF, wbS, wbF;
      waitMem = s.dReq && !s.dReady;
      busy    = mdInFlight ? !s.mdDone : s.mdStart;
      hazard  = s.memRead && (s.rd != 5'd0) &&
                ((s.rs1Used && s.rs1 == s.rd) || (s.rs2Used && s.rs2 == s.rd));
      {pc, ifS, ifF, idS, idF, exS, exF, wbS, wbF} = '0;
      if (waitMem) begin
         {pc, ifS, idS, exS, wbS} = 5'b11111;
         wbF = 1'b1;
      end else if (busy) begin
         {pc, ifS, idS} = 3'b111;
         exF = 1'b1;
      end else if (s.branch) begin
         ifF = 1'b1;
         idF = 1'b1;
      end else if (hazard) begin
         pc  = 1'b1;
         ifS = 1'b1;
         idF = 1'b1;
      end
      ifS = ifS && !ifF;
      idS = idS && !idF;
      exS = exS && !exF;
      wbS = wbS && !wbF;
      e.ctrl     = {pc, ifS, ifF, idS, idF, exS, exF, wbS, wbF};
      e.err      = modelErr;
      e.stallCnt = modelStalls;
      e.flushCnt = modelFlushes;

      modelStalls = modelStalls + CNT_W'(pc);
      if (!waitMem && !busy && s.branch) modelFlushes = modelFlushes + 1'b1;
      modelErr = 1'b0;
      if (!waitMem) begin
         if (mdInFlight) begin
            if (s.mdDone) begin
               mdInFlight = 1'b0;
            end else if (mdAge == MD_TIMEOUT) begin
               mdInFlight = 1'b0;
               modelErr   = 1'b1;
            end else begin
               mdAge++;
            end
         end else if (s.mdStart) begin
            mdInFlight = 1'b1;
            mdAge      = 1;
         end
      end
   endtask

   task automatic driveInputs(input stim_t s);
      hif.IDRs1         = s.rs1;
      hif.IDRs2         = s.rs2;
      hif.IDRs1Used     = s.rs1Used;
      hif.IDRs2Used     = s.rs2Used;
      hif.EXRd          = s.rd;
      hif.EXMemRead     = s.memRead;
      hif.EXBranchTaken = s.branch;
      hif.MulDivStart   = s.mdStart;
      hif.MulDivDone    = s.mdDone;
      hif.DMemReq       = s.dReq;
      hif.DMemReady     = s.dReady;
   endtask

   // Drive one cycle of stimulus just after the rising edge and queue its expectation.
   task automatic applyStimulus(input stim_t s);
      expect_t e;
      @(posedge clk);
      #1;
      rst = 1'b1;
      driveInputs(s);
      modelStep(s, e);
      expQ.push_back(e);
   endtask

   // Assert reset mid-cycle for two cycles; outputs and counters must read zero at once.
   task automatic doReset(input stim_t s);
      expect_t e;
      e.ctrl     = '0;
      e.err      = 1'b0;
      e.stallCnt = '0;
      e.flushCnt = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      driveInputs(s);
      modelReset();
      expQ.push_back(e);
      @(posedge clk);
      #1;
      expQ.push_back(e);
   endtask

   task automatic compareField(input string name, input logic [CNT_W-1:0] actual,
                               input logic [CNT_W-1:0] required);
      testsRun++;
      if (actual !== required) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, required);
      end
   endtask

   task automatic checkOutput(input expect_t e);
      logic [8:0] act;
      act = {hif.PcStall, hif.IFIDStall, hif.IFIDFlush, hif.IDEXStall, hif.IDEXFlush,
             hif.EXMEMStall, hif.EXMEMFlush, hif.MEMWBStall, hif.MEMWBFlush};
      compareField("ctrl", CNT_W'(act), CNT_W'(e.ctrl));
      compareField("MulDivError", CNT_W'(hif.MulDivError), CNT_W'(e.err));
      compareField("StallCount", hif.StallCount, e.stallCnt);
      compareField("FlushCount", hif.FlushCount, e.flushCnt);
   endtask

   // Monitor: at every falling edge, settle against the oldest pending expectation.
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   // Stimulus: directed hazard scenarios, then randomized traffic.
   initial begin
      stim_t s;
      rst = 1'b0;
      driveInputs(idleStim());
      modelReset();
      doReset(idleStim());

      // Load-use on rs1 for one cycle, then idle.
      s = idleStim(); s.memRead = 1; s.rd = 5; s.rs1 = 5; s.rs1Used = 1;
      applyStimulus(s);
      applyStimulus(idleStim());

      // x0 producer and unused-operand match must not stall.
      s = idleStim(); s.memRead = 1; s.rd = 0; s.rs1 = 0; s.rs1Used = 1;
      applyStimulus(s);
      s = idleStim(); s.memRead = 1; s.rd = 5; s.rs2 = 5; s.rs2Used = 0;
      applyStimulus(s);

      // Redirect with a same-cycle load-use.
      s = idleStim(); s.branch = 1; s.memRead = 1; s.rd = 7; s.rs2 = 7; s.rs2Used = 1;
      applyStimulus(s);
      applyStimulus(idleStim());

      // Mul/div: start in cycle 0, done in cycle 4.
      s = idleStim(); s.mdStart = 1;
      applyStimulus(s);
      repeat (3) applyStimulus(idleStim());
      s = idleStim(); s.mdDone = 1;
      applyStimulus(s);
      applyStimulus(idleStim());

      // Timeout: start and never complete, then a normal start/done afterwards.
      s = idleStim(); s.mdStart = 1;
      applyStimulus(s);
      repeat (MD_TIMEOUT + 3) applyStimulus(idleStim());
      s = idleStim(); s.mdStart = 1;
      applyStimulus(s);
      applyStimulus(idleStim());
      s = idleStim(); s.mdDone = 1;
      applyStimulus(s);

      // Memory wait during MD_BUSY, then reset in the middle of the wait.
      s = idleStim(); s.mdStart = 1;
      applyStimulus(s);
      applyStimulus(idleStim());
      s = idleStim(); s.dReq = 1; s.dReady = 0;
      repeat (3) applyStimulus(s);
      doReset(s);
      applyStimulus(idleStim());

      // Random traffic over a narrow register range so hazards and x0 cases are frequent.
      for (int i = 0; i < 600; i++) begin
         s.rs1     = 5'($urandom_range(0, 3));
         s.rs2     = 5'($urandom_range(0, 3));
         s.rs1Used = 1'($urandom_range(0, 1));
         s.rs2Used = 1'($urandom_range(0, 1));
         s.rd      = 5'($urandom_range(0, 3));
         s.memRead = ($urandom_range(0, 2) == 0);
         s.branch  = ($urandom_range(0, 7) == 0);
         s.mdStart = ($urandom_range(0, 7) == 0);
         s.mdDone  = ($urandom_range(0, 3) == 0);
         s.dReq    = ($urandom_range(0, 3) == 0);
         s.dReady  = ($urandom_range(0, 1) == 0);
         if ($urandom_range(0, 149) == 0) doReset(s);
         else applyStimulus(s);
      end

      @(negedge clk);
      @(negedge clk);
      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Detects load-use data hazards, EX-stage branch/jump redirects, multi-cycle mul/div occupancy and data-memory wait.
- Drives the per-register hold (DataHazard-style) and bubble (ControlHazard-style) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps stall and flush performance counters.

Parameters:
- MD_TIMEOUT, 64, maximum cycles the block stays in MD_BUSY before forcing release and flagging an error.
- CNT_W, 32, width of the performance counters; counters wrap modulo 2^CNT_W.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- IDRs1  in  5  rs1 index of the instruction in ID.
- IDRs2  in  5  rs2 index of the instruction in ID.
- IDRs1Used  in  1  ID instruction reads rs1.
- IDRs2Used  in  1  ID instruction reads rs2.
- EXRd  in  5  destination index of the instruction in EX.
- EXMemRead  in  1  EX instruction is a load.
- EXBranchTaken  in  1  EX resolved a taken branch or jump (redirect).
- MulDivStart  in  1  EX holds a mul/div op, first cycle.
- MulDivDone  in  1  mul/div result valid this cycle.
- DMemReq  in  1  MEM stage access active.
- DMemReady  in  1  data memory completes the access this cycle.
- PcStall  out  1  hold PC.
- IFIDStall  out  1  hold IF/ID.
- IFIDFlush  out  1  zero IF/ID.
- IDEXStall  out  1  hold ID/EX.
- IDEXFlush  out  1  zero ID/EX (bubble).
- EXMEMStall  out  1  hold EX/MEM.
- EXMEMFlush  out  1  zero EX/MEM.
- MEMWBStall  out  1  hold MEM/WB.
- MEMWBFlush  out  1  zero MEM/WB.
- MulDivError  out  1  one-cycle pulse on timeout.
- StallCount  out  CNT_W  cycles with PcStall=1.
- FlushCount  out  CNT_W  taken redirects accepted.

Behaviour:
- Reset (rst=0, async):
  - State goes to RUN; busy counter, StallCount and FlushCount clear to 0; MulDivError=0.
  - All stall/flush outputs are forced to 0 while rst=0.
- Stall/flush outputs are combinational from registered state and current inputs, so they are valid in the same cycle. State and counters update on the rising clk edge.
- Where stall and flush are both asserted on one register, flush wins.
- States:
  - RUN: MulDivStart=1 (and no DMem wait) -> MD_BUSY, with the busy counter loaded to 1.
  - MD_BUSY: MulDivDone=1 -> RUN. Busy counter reaching MD_TIMEOUT -> RUN with MulDivError pulsed for 1 cycle. Otherwise the counter increments.
- Hazard priority, highest first:
  1. DMem wait.
  2. Mul/div busy.
  3. Redirect.
  4. Load-use.
- DMem wait (DMemReq=1 and DMemReady=0), valid in any state:
  - All stalls = 1; MEMWBFlush=1; all other flushes = 0.
  - FSM state and busy counter frozen (no transition, no increment).
- Mul/div busy ((state=RUN and MulDivStart=1) or (state=MD_BUSY and MulDivDone=0)):
  - PcStall, IFIDStall, IDEXStall = 1; EXMEMFlush=1.
  - EX/MEM does not stall; MEM/WB is unaffected.
- Mul/div completion (state=MD_BUSY and MulDivDone=1): no stall in that cycle, so the result advances to EX/MEM.
- Redirect (EXBranchTaken=1, no higher-priority condition):
  - IFIDFlush=1 and IDEXFlush=1; no stalls.
  - FlushCount += 1.
  - A load-use hazard detected in the same cycle is ignored (wrong-path instruction).
- Load-use (EXMemRead=1, EXRd!=0, and (IDRs1Used and IDRs1==EXRd) or (IDRs2Used and IDRs2==EXRd)):
  - PcStall=1, IFIDStall=1, IDEXFlush=1. Exactly one bubble; the hazard clears itself next cycle.
  - Register x0 never causes a hazard.
- StallCount increments on every clock edge where PcStall=1, including DMem wait. No saturation; wraps.
- No condition active: all outputs 0.

Test Plan:
- Load-use: EXMemRead=1, EXRd=5, IDRs1=5, IDRs1Used=1 for 1 cycle -> PcStall=IFIDStall=IDEXFlush=1 that cycle only; StallCount 0->1.
- x0/unused: EXMemRead=1, EXRd=0, IDRs1=0 -> no stall. Same with EXRd=5, IDRs2=5, IDRs2Used=0 -> no stall.
- Redirect with load-use in the same cycle: EXBranchTaken=1 plus a matching load-use -> IFIDFlush=IDEXFlush=1, PcStall=0; FlushCount=1.
- Mul/div: MulDivStart at cycle 0, MulDivDone at cycle 4 -> PcStall=EXMEMFlush=1 in cycles 0-3, 0 in cycle 4; state RUN at cycle 5; StallCount=4.
- Timeout with MD_TIMEOUT=8: MulDivStart, never Done -> release after 8 busy cycles; MulDivError pulses exactly 1 cycle; later Start re-enters MD_BUSY normally.
- DMem wait during MD_BUSY: DMemReady=0 for 3 cycles -> all stalls=1, MEMWBFlush=1, busy counter frozen. Then assert rst=0 mid-wait -> outputs immediately 0, state RUN, counters 0.
